// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions for the modulator, its serializer and the sine lookup.
// Contents:
//   DATA_WIDTH, WAVELENGTH, AMPLITUDE, PREAMBLE  default framing/waveform constants
//   phase_t       16-bit carrier phase counter type (same width as the receiver)
//   bpsk_state_e  transmitter state: ST_IDLE, ST_PREAMBLE, ST_DATA
package bpsk_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int WAVELENGTH = 64;
  localparam int AMPLITUDE = 2 ** (DATA_WIDTH - 1) - 1;
  localparam logic [7:0] PREAMBLE = 8'b0101_0101;
  localparam int PHASE_WIDTH = 16;

  typedef logic [PHASE_WIDTH-1:0] phase_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2
  } bpsk_state_e;
endpackage

// File: rtl/bpsk_signal_modulator_if.sv
// Byte-input / waveform-output bundle of the BPSK modulator.
// Handshake: a byte moves on a rising clock edge where data_valid and
// data_ready are both 1. data_ready never depends on data_valid; data_in is
// only looked at in a cycle where the transfer happens.
// Signals:
//   data_in[7:0]   byte to send, LSB first        (master -> slave)
//   data_valid     data_in is valid               (master -> slave)
//   data_ready     modulator takes data_in now    (slave -> master)
//   signal         unsigned modulated sample      (slave -> master)
//   busy           frame in progress              (slave -> master)
//   bit_strobe     first sample of each bit       (slave -> master)
interface bpsk_signal_modulator_if #(
  parameter int DATA_WIDTH = bpsk_pkg::DATA_WIDTH
);
  logic [7:0]            data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] signal;
  logic                  busy;
  logic                  bit_strobe;

  modport master (
    output data_in, data_valid,
    input  data_ready, signal, busy, bit_strobe
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, signal, busy, bit_strobe
  );
endinterface

// File: rtl/bpsk_bit_serializer.sv
// 8-bit LSB-first serializer used for both the preamble and the data bytes.
// Ports:
//   clock, reset_n  clock and synchronous active-low reset
//   load            take load_value and restart at bit 0 (wins over shift)
//   shift           advance to the next bit
//   load_value      byte to serialize
//   bit_out         bit currently being transmitted
//   last            bit_out is bit 7 of the loaded byte
module bpsk_bit_serializer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] load_value,
  output logic       bit_out,
  output logic       last
);
  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    sr_d = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d = load_value;
      cnt_d = 3'd0;
    end else if (shift) begin
      sr_d = {1'b0, sr_q[7:1]};
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sr_q <= '0;
      cnt_q <= '0;
    end else begin
      sr_q <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_out = sr_q[0];
  assign last = (cnt_q == 3'd7);
endmodule

// File: rtl/wave_table_sine.sv
// Shared sine lookup: signed carrier sample for a phase in 0..WAVELENGTH-1.
// Each half period is a parabola 4*x*(H-x)/H^2 scaled to the full positive
// range, so the peak (at WAVELENGTH/4) is exactly 2**(DATA_WIDTH-1)-1 and the
// second half is the negated first half.
// Ports:
//   phase      in   carrier phase, 0..WAVELENGTH-1
//   amplitude  out  signed DATA_WIDTH sample
module wave_table_sine #(
  parameter int DATA_WIDTH = 16,
  parameter int WAVELENGTH = 64
) (
  input  bpsk_pkg::phase_t              phase,
  output logic signed [DATA_WIDTH-1:0]  amplitude
);
  localparam int HALF = WAVELENGTH / 2;
  localparam logic [47:0] PEAK = 48'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic [47:0] HALF_SQ = 48'(HALF * HALF);

  logic                         neg;
  logic [15:0]                  x;
  logic [47:0]                  num;
  logic [47:0]                  mag;
  logic signed [DATA_WIDTH-1:0] mag_s;

  always_comb begin
    neg = (phase >= 16'(HALF));
    x = neg ? (phase - 16'(HALF)) : phase;
    num = 48'(4) * 48'(x) * (48'(HALF) - 48'(x)) * PEAK;
    mag = num / HALF_SQ;
    mag_s = DATA_WIDTH'(mag);
    amplitude = neg ? -mag_s : mag_s;
  end
endmodule

// File: rtl/bpsk_signal_modulator.sv
// BPSK transmitter: accepts bytes, sends PREAMBLE then the bytes LSB-first,
// one carrier period (WAVELENGTH samples) per bit, on an unsigned output
// offset by AMPLITUDE. Bit 0 -> AMPLITUDE + sine, bit 1 -> AMPLITUDE - sine.
// A byte offered in the final sample of the last data bit chains onto the
// frame with no gap and no new preamble.
// Optional build macro BPSK_IDLE_CARRIER_EN: when defined, IDLE outputs a
// free-running bit-0 carrier; otherwise IDLE holds AMPLITUDE with phase 0.
// Ports:
//   clock, reset_n  clock and synchronous active-low reset
//   bus             slave side of bpsk_signal_modulator_if
//   state_dbg       current FSM state
module bpsk_signal_modulator
  import bpsk_pkg::*;
#(
  parameter int DATA_WIDTH = bpsk_pkg::DATA_WIDTH,
  parameter int WAVELENGTH = bpsk_pkg::WAVELENGTH,
  parameter int AMPLITUDE = 2 ** (DATA_WIDTH - 1) - 1,
  parameter logic [7:0] PREAMBLE = bpsk_pkg::PREAMBLE
) (
  input  logic                    clock,
  input  logic                    reset_n,
  bpsk_signal_modulator_if.slave  bus,
  output bpsk_state_e             state_dbg
);
  localparam phase_t LAST_PHASE = phase_t'(WAVELENGTH - 1);
  localparam logic signed [DATA_WIDTH:0] AMP_S = (DATA_WIDTH + 1)'(AMPLITUDE);
  localparam logic [DATA_WIDTH-1:0] IDLE_LEVEL = DATA_WIDTH'(AMPLITUDE);

  bpsk_state_e           state_q, state_d;
  phase_t                phase_q, phase_d;
  logic [7:0]            byte_q, byte_d;
  logic [DATA_WIDTH-1:0] signal_q, signal_d;
  logic                  ready_en_q, ready_en_d;

  logic                         ser_load, ser_shift, ser_bit, ser_last;
  logic [7:0]                   ser_value;
  logic signed [DATA_WIDTH-1:0] amp;
  logic signed [DATA_WIDTH:0]   amp_x;
  logic signed [DATA_WIDTH:0]   sum;
  logic                         bit_end, data_ready, transfer;

  wave_table_sine #(
    .DATA_WIDTH(DATA_WIDTH),
    .WAVELENGTH(WAVELENGTH)
  ) u_table (
    .phase    (phase_q),
    .amplitude(amp)
  );

  bpsk_bit_serializer u_ser (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (ser_load),
    .shift     (ser_shift),
    .load_value(ser_value),
    .bit_out   (ser_bit),
    .last      (ser_last)
  );

  assign amp_x = {amp[DATA_WIDTH-1], amp};
  assign bit_end = (phase_q == LAST_PHASE);

  // ready_en_q keeps data_ready low for the first cycle after reset release.
  always_comb begin
    data_ready = 1'b0;
    case (state_q)
      ST_IDLE: data_ready = ready_en_q;
      ST_DATA: data_ready = bit_end && ser_last;
      default: data_ready = 1'b0;
    endcase
  end

  assign transfer = bus.data_valid && data_ready;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    byte_d = byte_q;
    ready_en_d = 1'b1;
    ser_load = 1'b0;
    ser_shift = 1'b0;
    ser_value = byte_q;
    sum = AMP_S;
    signal_d = IDLE_LEVEL;
    case (state_q)
      ST_IDLE: begin
`ifdef BPSK_IDLE_CARRIER_EN
        sum = AMP_S + amp_x;
        signal_d = DATA_WIDTH'(sum);
        phase_d = bit_end ? '0 : phase_q + phase_t'(1);
`else
        phase_d = '0;
`endif
        if (transfer) begin
          state_d = ST_PREAMBLE;
          phase_d = '0;
          byte_d = bus.data_in;
          ser_load = 1'b1;
          ser_value = PREAMBLE;
        end
      end
      ST_PREAMBLE, ST_DATA: begin
        sum = ser_bit ? (AMP_S - amp_x) : (AMP_S + amp_x);
        signal_d = DATA_WIDTH'(sum);
        phase_d = bit_end ? '0 : phase_q + phase_t'(1);
        if (bit_end) begin
          if (!ser_last) begin
            ser_shift = 1'b1;
          end else if (state_q == ST_PREAMBLE) begin
            state_d = ST_DATA;
            ser_load = 1'b1;
            ser_value = byte_q;
          end else if (transfer) begin
            // Chained byte goes straight into the serializer.
            ser_load = 1'b1;
            ser_value = bus.data_in;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      byte_q <= '0;
      signal_q <= IDLE_LEVEL;
      ready_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      byte_q <= byte_d;
      signal_q <= signal_d;
      ready_en_q <= ready_en_d;
    end
  end

  assign bus.data_ready = data_ready;
  assign bus.signal = signal_q;
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.bit_strobe = (state_q != ST_IDLE) && (phase_q == '0);
  assign state_dbg = state_q;
endmodule

// File: tb/tb_bpsk_signal_modulator.sv
// Testbench for bpsk_signal_modulator (WAVELENGTH=16). The reference model
// expands each frame into its bit list (preamble + bytes, LSB first) and
// predicts every sample, strobe, busy and ready cycle from that list.
module tb_bpsk_signal_modulator;
  import bpsk_pkg::*;

  localparam int DW = 16;
  localparam int W = 16;
  localparam int AMP = 2 ** (DW - 1) - 1;
  localparam int PEAK = AMP;
  localparam logic [7:0] PRE = 8'b0101_0101;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bpsk_signal_modulator_if #(.DATA_WIDTH(DW)) bus ();
  bpsk_state_e state_dbg;

  bpsk_signal_modulator #(
    .DATA_WIDTH(DW),
    .WAVELENGTH(W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // Separate instance of the shared lookup used to build the sample table.
  phase_t               ref_phase;
  logic signed [DW-1:0] ref_amp;
  wave_table_sine #(.DATA_WIDTH(DW), .WAVELENGTH(W)) u_ref (
    .phase    (ref_phase),
    .amplitude(ref_amp)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int sine_ref[W];
  logic [7:0] tx_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];

  task automatic test_reset();
    bus.data_in = 8'h00;
    bus.data_valid = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++; if (bus.signal !== DW'(AMP)) begin n_fail++; $display("FAIL reset_signal got=%0d exp=%0d", bus.signal, AMP); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.data_ready); end
    n_cmp++; if (bus.bit_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got=%b exp=0", bus.bit_strobe); end
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    reset_n = 1'b1;
    n_cmp++; if (bus.data_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_early got=%b exp=0", bus.data_ready); end
    @(negedge clock);
    n_cmp++; if (bus.data_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got=%b exp=1", bus.data_ready); end
  endtask

  task automatic test_sine_ref();
    for (int p = 0; p < W; p++) begin
      ref_phase = phase_t'(p);
      #1;
      sine_ref[p] = ref_amp;
    end
    n_cmp++; if (sine_ref[0] !== 0) begin n_fail++; $display("FAIL sine_zero got=%0d exp=0", sine_ref[0]); end
    n_cmp++; if (sine_ref[W/4] !== PEAK) begin n_fail++; $display("FAIL sine_peak got=%0d exp=%0d", sine_ref[W/4], PEAK); end
    n_cmp++; if (sine_ref[3*W/4] !== -PEAK) begin n_fail++; $display("FAIL sine_trough got=%0d exp=%0d", sine_ref[3*W/4], -PEAK); end
    for (int p = 0; p < W / 2; p++) begin
      n_cmp++;
      if (sine_ref[p + W/2] !== -sine_ref[p]) begin
        n_fail++; $display("FAIL sine_antisym p=%0d got=%0d exp=%0d", p, sine_ref[p + W/2], -sine_ref[p]);
      end
    end
  endtask

  // Sends tx_q as one frame (chained bytes). The byte after the current one
  // is offered with data_valid from frame cycle assert_at onward.
  task automatic run_frame(input int assert_at, input string tag);
    int n, total, nxt, b, p, guard, v;
    logic bits[$];
    logic exp_ready, exp_strobe;
    logic [DW-1:0] exp_sig;
    n = tx_q.size();
    total = (8 + 8 * n) * W;
    bits.delete();
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < 8; i++) bits.push_back(PRE[i]);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 8; i++) bits.push_back(tx_q[k][i]);
`ifndef BPSK_IDLE_CARRIER_EN
    exp_q.push_back(DW'(AMP));
`endif
    bus.data_in = tx_q[0];
    bus.data_valid = 1'b1;
    guard = 0;
    while (bus.data_ready !== 1'b1 && guard < 64) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 64) begin
      n_cmp++; n_fail++;
      $display("FAIL %s accept_timeout got=ready_low exp=ready_high", tag);
      bus.data_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    nxt = 1;
    if (nxt < n && assert_at == 0) begin bus.data_valid = 1'b1; bus.data_in = tx_q[nxt]; end
    else begin bus.data_valid = 1'b0; bus.data_in = 8'($urandom); end
    @(negedge clock);
    for (int c = 0; c < total; c++) begin
      b = c / W;
      p = c % W;
      exp_ready = (b >= 8) && ((b % 8) == 7) && (p == W - 1);
      exp_strobe = (p == 0);
      n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL %s busy c=%0d got=%b exp=1", tag, c, bus.busy); end
      n_cmp++; if (bus.bit_strobe !== exp_strobe) begin n_fail++; $display("FAIL %s strobe c=%0d got=%b exp=%b", tag, c, bus.bit_strobe, exp_strobe); end
      n_cmp++; if (bus.data_ready !== exp_ready) begin n_fail++; $display("FAIL %s ready c=%0d got=%b exp=%b", tag, c, bus.data_ready, exp_ready); end
      if (c > 0) obs_q.push_back(bus.signal);
      if (exp_q.size() > 0) begin
        exp_sig = exp_q.pop_front();
        n_cmp++; if (bus.signal !== exp_sig) begin n_fail++; $display("FAIL %s signal c=%0d got=%0d exp=%0d", tag, c, bus.signal, exp_sig); end
      end
      v = bits[b] ? (AMP - sine_ref[p]) : (AMP + sine_ref[p]);
      exp_q.push_back(DW'(v));
      @(posedge clock); #1;
      if (exp_ready && bus.data_valid) nxt++;
      if (nxt < n && c + 1 >= assert_at) begin bus.data_valid = 1'b1; bus.data_in = tx_q[nxt]; end
      else begin bus.data_valid = 1'b0; bus.data_in = 8'($urandom); end
      @(negedge clock);
    end
    obs_q.push_back(bus.signal);
    exp_sig = exp_q.pop_front();
    n_cmp++; if (bus.signal !== exp_sig) begin n_fail++; $display("FAIL %s last_sample got=%0d exp=%0d", tag, bus.signal, exp_sig); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s end_busy got=%b exp=0", tag, bus.busy); end
    n_cmp++; if (bus.data_ready !== 1'b1) begin n_fail++; $display("FAIL %s end_ready got=%b exp=1", tag, bus.data_ready); end
    @(negedge clock);
`ifndef BPSK_IDLE_CARRIER_EN
    n_cmp++; if (bus.signal !== DW'(AMP)) begin n_fail++; $display("FAIL %s idle_signal got=%0d exp=%0d", tag, bus.signal, AMP); end
`endif
    n_cmp++; if (bus.bit_strobe !== 1'b0) begin n_fail++; $display("FAIL %s idle_strobe got=%b exp=0", tag, bus.bit_strobe); end
  endtask

  task automatic test_single_byte();
    tx_q = {8'hA5};
    run_frame(0, "single_a5");
    n_cmp++; if (obs_q.size() != 16 * W) begin n_fail++; $display("FAIL single_len got=%0d exp=%0d", obs_q.size(), 16 * W); end
  endtask

  task automatic test_waveform();
    // Uses the A5 frame: preamble bit 0 is a 1, preamble bit 1 is a 0.
    n_cmp++; if (obs_q[4] !== DW'(AMP - PEAK)) begin n_fail++; $display("FAIL wave_bit1_quarter got=%0d exp=%0d", obs_q[4], AMP - PEAK); end
    n_cmp++; if (obs_q[W + 4] !== DW'(AMP + PEAK)) begin n_fail++; $display("FAIL wave_bit0_quarter got=%0d exp=%0d", obs_q[W + 4], AMP + PEAK); end
  endtask

  task automatic test_chaining();
    tx_q = {8'h00, 8'hFF};
    run_frame(0, "chain");
    n_cmp++; if (obs_q.size() != 24 * W) begin n_fail++; $display("FAIL chain_len got=%0d exp=%0d", obs_q.size(), 24 * W); end
  endtask

  task automatic test_back_pressure();
    tx_q = {8'h5A, 8'h96};
    run_frame(9 * W + 3, "backpressure");
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    bus.data_in = 8'h3C;
    bus.data_valid = 1'b1;
    guard = 0;
    while (bus.data_ready !== 1'b1 && guard < 64) begin @(negedge clock); guard++; end
    n_cmp++; if (guard >= 64) begin n_fail++; $display("FAIL midreset_accept got=ready_low exp=ready_high"); end
    @(posedge clock); #1;
    bus.data_valid = 1'b0;
    repeat (3 * W + 5) @(negedge clock);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midreset_prebusy got=%b exp=1", bus.busy); end
    reset_n = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.signal !== DW'(AMP)) begin n_fail++; $display("FAIL midreset_signal got=%0d exp=%0d", bus.signal, AMP); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.data_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready got=%b exp=0", bus.data_ready); end
    n_cmp++; if (bus.bit_strobe !== 1'b0) begin n_fail++; $display("FAIL midreset_strobe got=%b exp=0", bus.bit_strobe); end
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++; if (bus.data_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_release_ready got=%b exp=1", bus.data_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_release_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 3);
      tx_q.delete();
      for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
      run_frame($urandom_range(0, 16 * W - 1), "random");
      repeat ($urandom_range(0, 5)) @(negedge clock);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sine_ref();
    test_single_byte();
    test_waveform();
    test_chaining();
    test_back_pressure();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
